// File: rtl/digit_scanner_pkg.sv
// Shared constants and helpers for the digit_scanner block: scan state
// encodings, code width and a counter-width helper.
package digit_scanner_pkg;

   // Scan phase encoding: blanking gap first, then the driven part of the slot.
   localparam logic [0:0] ST_BLANK = 1'b0;
   localparam logic [0:0] ST_DRIVE = 1'b1;

   // Width of one display code handed to the segment decoder.
   localparam int CODE_W = 4;

   // Counter width for a range of n values, never narrower than one bit.
   function automatic int min1_clog2(input int n);
      int w;
      w = $clog2(n);
      if (w < 1) begin
         return 1;
      end else begin
         return w;
      end
   endfunction

endpackage

// File: rtl/digit_scanner_checker.sv
// Property checker for digit_scanner outputs: at most one position enabled,
// and the displayed code never changes while a position is lit.
module digit_scanner_checker #(
   parameter int NUM_DIGITS = 4
) (
   input logic                  clk,
   input logic                  rst,
   input logic [3:0]            digit,
   input logic [NUM_DIGITS-1:0] digit_en
);

   // Never two positions driven at once.
   a_en_onehot0: assert property (@(posedge clk) disable iff (rst)
      $onehot0(digit_en))
      else $error("digit_en not one-hot: %b", digit_en);

   // Code must already be settled whenever an enable is high.
   a_digit_stable: assert property (@(posedge clk) disable iff (rst)
      (digit_en != {NUM_DIGITS{1'b0}}) |-> $stable(digit))
      else $error("digit changed while enabled: %h", digit);

endmodule

// File: rtl/digit_scanner_scan_timer.sv
// Slot timer for the digit scanner. Counts the cycles of one digit slot,
// splitting it into a leading blanking gap and a driven part, and flags
// the last cycle of the slot.
module scan_timer
   import digit_scanner_pkg::*;
#(
   parameter  int SCAN_DIV     = 50000,
   parameter  int BLANK_CYCLES = 16,
   localparam int CNT_W        = min1_clog2(SCAN_DIV)
) (
   input  logic clk,
   input  logic rst,
   output logic slot_end,
   output logic in_drive
);

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);

   logic [0:0]       state;
   logic [CNT_W-1:0] cnt;

   // Advance the slot counter and switch between blanking and driving.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_BLANK;
         cnt   <= {CNT_W{1'b0}};
      end else begin
         case (state)
            ST_BLANK: begin
               cnt <= cnt + CNT_W'(1);
               if (cnt == BLANK_LAST) begin
                  state <= ST_DRIVE;
               end else begin
                  state <= ST_BLANK;
               end
            end
            ST_DRIVE: begin
               if (cnt == SLOT_LAST) begin
                  cnt   <= {CNT_W{1'b0}};
                  state <= ST_BLANK;
               end else begin
                  cnt   <= cnt + CNT_W'(1);
                  state <= ST_DRIVE;
               end
            end
            default: begin
               cnt   <= {CNT_W{1'b0}};
               state <= ST_BLANK;
            end
         endcase
      end
   end

   // Phase and end-of-slot flags decoded from the registered state only.
   always_comb begin
      in_drive = (state == ST_DRIVE);
      slot_end = (state == ST_DRIVE) && (cnt == SLOT_LAST);
   end

endmodule

// File: rtl/digit_scanner.sv
// Time-multiplexed scan controller for a bank of 7-segment digits.
// Accepts a packed word of 4-bit codes over valid/ready into a one-entry
// pending buffer; the word becomes the displayed word only at a frame
// boundary so a frame never shows a mix of old and new digits.
module digit_scanner
   import digit_scanner_pkg::*;
#(
   parameter  int NUM_DIGITS   = 4,
   parameter  int SCAN_DIV     = 50000,
   parameter  int BLANK_CYCLES = 16,
   localparam int IDX_W        = min1_clog2(NUM_DIGITS),
   localparam int WORD_W       = CODE_W * NUM_DIGITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [WORD_W-1:0]     load_data,
   output logic [CODE_W-1:0]     digit,
   output logic [NUM_DIGITS-1:0] digit_en,
   output logic [IDX_W-1:0]      digit_idx
);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic              slot_end;
   logic              in_drive;
   logic [IDX_W-1:0]  idx;
   logic [WORD_W-1:0] active;
   logic [WORD_W-1:0] pending;
   logic              pending_full;
   logic              frame_end;
   logic              accept;

   scan_timer #(
      .SCAN_DIV     (SCAN_DIV),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_scan_timer (
      .clk      (clk),
      .rst      (rst),
      .slot_end (slot_end),
      .in_drive (in_drive)
   );

   // Handshake and frame-boundary decode. Ready is forced low during reset
   // so nothing is accepted while the block is being cleared.
   always_comb begin
      load_ready = !pending_full && !rst;
      accept     = load_valid && load_ready;
      frame_end  = slot_end && (idx == IDX_LAST);
   end

   // Step to the next position at the end of every slot, wrapping after the last.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx <= {IDX_W{1'b0}};
      end else if (slot_end) begin
         if (idx == IDX_LAST) begin
            idx <= {IDX_W{1'b0}};
         end else begin
            idx <= idx + IDX_W'(1);
         end
      end else begin
         idx <= idx;
      end
   end

   // Double buffer: capture offered words, promote them only at a frame boundary.
   // A capture and a promotion never coincide because ready is low while full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active       <= {WORD_W{1'b0}};
         pending      <= {WORD_W{1'b0}};
         pending_full <= 1'b0;
      end else if (frame_end && pending_full) begin
         active       <= pending;
         pending      <= pending;
         pending_full <= 1'b0;
      end else if (accept) begin
         active       <= active;
         pending      <= load_data;
         pending_full <= 1'b1;
      end else begin
         active       <= active;
         pending      <= pending;
         pending_full <= pending_full;
      end
   end

   // Display outputs from registers only: the code of the current position
   // and its enable, which stays off for the blanking part of the slot.
   always_comb begin
      digit     = {CODE_W{1'b0}};
      digit_en  = {NUM_DIGITS{1'b0}};
      digit_idx = idx;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         digit       = digit | ({CODE_W{idx == IDX_W'(i)}} & active[CODE_W*i +: CODE_W]);
         digit_en[i] = in_drive && (idx == IDX_W'(i));
      end
   end

endmodule

// File: tb/tb_digit_scanner.sv
// Scoreboard bench for digit_scanner (4 digits, 8-cycle slot, 2-cycle gap).
// Stimulus pushes per-cycle expected outputs keyed by cycle number; a
// monitor pops and compares them on the falling edge.
module tb_digit_scanner;

   logic        clk;
   logic        rst;
   logic        load_valid;
   logic        load_ready;
   logic [15:0] load_data;
   logic [3:0]  digit;
   logic [3:0]  digit_en;
   logic [1:0]  digit_idx;

   typedef struct {
      int         cyc;
      logic [3:0] en;
      logic [3:0] dig;
      logic [1:0] idx;
      logic       rdy;
      string      name;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   tcyc   = 0;
   int   checks = 0;
   int   errors = 0;

   localparam logic [15:0] W1 = 16'h4321;
   localparam logic [15:0] W2 = 16'h8765;
   localparam logic [15:0] W3 = 16'hDCBA;
   localparam logic [15:0] W4 = 16'h1234;

   digit_scanner #(
      .NUM_DIGITS   (4),
      .SCAN_DIV     (8),
      .BLANK_CYCLES (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .digit      (digit),
      .digit_en   (digit_en),
      .digit_idx  (digit_idx)
   );

   digit_scanner_checker #(.NUM_DIGITS(4)) u_chk (
      .clk      (clk),
      .rst      (rst),
      .digit    (digit),
      .digit_en (digit_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running edge counter used as the scoreboard time base.
   always @(posedge clk) tcyc <= tcyc + 1;

   // Monitor: compare every expectation whose cycle has arrived.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= tcyc) begin
         mon_e  = sb.pop_front();
         checks = checks + 1;
         if (mon_e.cyc != tcyc || digit_en !== mon_e.en || digit !== mon_e.dig ||
             digit_idx !== mon_e.idx || load_ready !== mon_e.rdy) begin
            errors = errors + 1;
            $display("FAIL %s cyc=%0d (want cyc %0d) got en=%b digit=%h idx=%0d ready=%b want en=%b digit=%h idx=%0d ready=%b",
                     mon_e.name, tcyc, mon_e.cyc, digit_en, digit, digit_idx, load_ready,
                     mon_e.en, mon_e.dig, mon_e.idx, mon_e.rdy);
         end
      end
   end

   // Expected enable k edges after reset release: gap of 2, then 6 lit cycles.
   function automatic logic [3:0] exp_en(input int k);
      logic [3:0] one;
      one = 4'b0001;
      if ((k % 8) >= 2) return one << ((k % 32) / 8);
      else return 4'b0000;
   endfunction

   task automatic push_one(input int cyc, input logic [3:0] en, input logic [3:0] dig,
                           input logic [1:0] idx, input logic rdy, input string name);
      exp_t e;
      e.cyc = cyc; e.en = en; e.dig = dig; e.idx = idx; e.rdy = rdy; e.name = name;
      sb.push_back(e);
   endtask

   // Expectations for cycles k0..k1 after a release at base, showing word w.
   task automatic push_span(input int base, input int k0, input int k1,
                            input logic [15:0] w, input logic rdy, input string name);
      logic [15:0] sh;
      int          slot;
      for (int k = k0; k <= k1; k++) begin
         slot = (k % 32) / 8;
         sh   = w >> (4 * slot);
         push_one(base + k, exp_en(k), sh[3:0], 2'(slot), rdy, name);
      end
   endtask

   task automatic wait_k(input int target);
      while (tcyc < target) @(negedge clk);
   endtask

   int b;
   int b2;
   int t;

   initial begin
      rst        = 1'b1;
      load_valid = 1'b0;
      load_data  = 16'h0000;
      for (int c = 1; c <= 3; c++) push_one(c, 4'b0000, 4'h0, 2'd0, 1'b0, "reset_state");
      repeat (4) @(posedge clk);
      #2;
      b   = tcyc;
      rst = 1'b0;

      push_span(b, 0, 35, 16'h0000, 1'b1, "idle_scan");
      push_span(b, 36, 63, 16'h0000, 1'b0, "w1_pending");
      push_span(b, 64, 64, W1, 1'b1, "w1_promoted");
      push_span(b, 65, 95, W1, 1'b0, "w1_shown_w2_held");
      push_span(b, 96, 126, W2, 1'b1, "w2_shown");
      push_span(b, 127, 127, W2, 1'b0, "w3_last_edge");
      push_span(b, 128, 134, W3, 1'b1, "w3_promoted");
      push_span(b, 135, 147, W3, 1'b0, "w4_pending");

      // First word, accepted on edge 36.
      wait_k(b + 35); load_valid = 1'b1; load_data = W1;
      wait_k(b + 36); load_valid = 1'b0; load_data = 16'h0000;
      // Second word offered while the buffer is full; taken on edge 65.
      wait_k(b + 40); load_valid = 1'b1; load_data = W2;
      wait_k(b + 65); load_valid = 1'b0; load_data = 16'h0000;
      // Third word accepted on the edge just before the boundary at 128.
      wait_k(b + 126); load_valid = 1'b1; load_data = W3;
      wait_k(b + 127); load_valid = 1'b0; load_data = 16'h0000;
      // Fourth word left pending, then discarded by reset.
      wait_k(b + 134); load_valid = 1'b1; load_data = W4;
      wait_k(b + 135); load_valid = 1'b0; load_data = 16'h0000;

      // Reset mid-drive at position 2: everything must clear without a clock edge.
      wait_k(b + 147);
      @(posedge clk);
      #2;
      rst = 1'b1;
      t   = tcyc;
      for (int c = 0; c < 3; c++) push_one(t + c, 4'b0000, 4'h0, 2'd0, 1'b0, "mid_reset");
      repeat (3) @(posedge clk);
      #2;
      b2  = tcyc;
      rst = 1'b0;
      push_span(b2, 0, 40, 16'h0000, 1'b1, "restart_scan");
      wait_k(b2 + 41);

      for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         $display("FAIL scoreboard_drain left=%0d", sb.size());
         errors = errors + sb.size();
         checks = checks + sb.size();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
